fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, pixel data width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive denied CPU-request cycles before a forced CPU grant.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_req  input  1  CPU single-pixel write request, held until granted.
REQ-006 SHALL have port cpu_addr  input  17  CPU frame-buffer write address.
REQ-007 SHALL have port cpu_data  input  DW  CPU write pixel.
REQ-008 SHALL have port cpu_gnt  output  1  combinational; CPU write accepted this cycle.
REQ-009 SHALL have port str_start  input  1  one-cycle pulse; begin a 256x256 image transfer.
REQ-010 SHALL have port str_slot  input  1  sampled with str_start; 0 = base 0, 1 = base 256.
REQ-011 SHALL have port str_valid  input  1  coprocessor pixel valid.
REQ-012 SHALL have port str_data  input  DW  coprocessor pixel.
REQ-013 SHALL have port str_ready  output  1  combinational; pixel accepted when str_valid & str_ready.
REQ-014 SHALL have port str_busy  output  1  high in STREAM state.
REQ-015 SHALL have port str_done  output  1  registered one-cycle pulse at transfer end.
REQ-016 SHALL have ports fb_we  output  1, fb_waddr  output  17, fb_wdata  output  DW; registered frame-buffer write port.

Function
REQ-017 SHALL implement FSM states IDLE and STREAM.
REQ-018 IDLE -> STREAM on str_start; latch base = str_slot ? 256 : 0; clear row and col counters (8 bits each).
REQ-019 STREAM -> IDLE on the cycle the 65536th pixel is accepted; str_done = 1 on the following cycle only.
REQ-020 str_start in STREAM SHALL abort the current transfer, relatch base, clear counters, stay in STREAM, no str_done.
REQ-021 str_ready SHALL be 0 in IDLE, including the str_start cycle.
REQ-022 In IDLE, cpu_gnt = cpu_req.
REQ-023 In STREAM, stream has priority: str_ready = 1 and cpu_gnt = 0 unless the starvation counter equals STARVE_MAX.
REQ-024 Starvation counter: increments each STREAM cycle with cpu_req & ~cpu_gnt, saturates at STARVE_MAX, clears on cpu_gnt or ~cpu_req.
REQ-025 When counter = STARVE_MAX and cpu_req: cpu_gnt = 1, str_ready = 0 that cycle.
REQ-026 Exactly one write SHALL be accepted per cycle; cpu_gnt & (str_valid & str_ready) never both 1.
REQ-027 Stream address SHALL be base + {row, 9'b0} + col (row stride 512), 17-bit, no overflow for legal counters.
REQ-028 On stream accept: col += 1; at col = 255, col wraps to 0 and row += 1.
REQ-029 fb_we/fb_waddr/fb_wdata SHALL update one cycle after accept with the accepted source's address/data; fb_we = 0 on cycles with no accept; fb_waddr/fb_wdata hold when fb_we = 0.
REQ-030 str_valid low SHALL stall counters without penalty; a CPU request in such a STREAM cycle SHALL be granted (cpu_gnt = cpu_req & ~(str_valid & str_ready)).

Reset
REQ-031 rst_n low SHALL force IDLE, counters/base/starvation counter to 0, fb_we = 0, fb_waddr = 0, fb_wdata = 0, str_done = 0, immediately, including mid-transfer.
REQ-032 After rst_n release, no write SHALL occur until cpu_req or str_start.

Verification
REQ-033 str_start with str_slot=0, str_valid held 1 for 65536 cycles -> fb_waddr sequence 0..255, 512..767, ..., last 130815; str_done one cycle after the final accept.
REQ-034 str_slot=1 -> first fb_waddr 256, address after col 255 of row 0 = 768, last = 131071.
REQ-035 STREAM with str_valid=1 continuously and cpu_req held with cpu_addr=0x1F000 -> cpu_gnt on 5th request cycle, str_ready = 0 that cycle, fb_waddr=0x1F000 next cycle, stream resumes without skipping an address.
REQ-036 IDLE, cpu_req=1, addr=5, data=0xAA -> cpu_gnt same cycle; fb_we=1, fb_waddr=5, fb_wdata=0xAA next cycle.
REQ-037 str_start again after 1000 pixels (slot 1) -> next write at address 256, no str_done pulse; str_done only after 65536 further pixels.
REQ-038 rst_n asserted after 300 pixels -> fb_we=0, str_busy=0 immediately; subsequent str_start slot 0 restarts at address 0.

Source files
------------

// File: rtl/fb_write_if.sv
// Frame-buffer write arbitration bus: CPU single-pixel port, coprocessor stream
// port and the registered frame-buffer write port.
interface fb_write_if #(
    parameter int unsigned DW = 8
);
    logic          cpu_req;
    logic [16:0]   cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_gnt;
    logic          str_start;
    logic          str_slot;
    logic          str_valid;
    logic [DW-1:0] str_data;
    logic          str_ready;
    logic          str_busy;
    logic          str_done;
    logic          fb_we;
    logic [16:0]   fb_waddr;
    logic [DW-1:0] fb_wdata;

    // Requesters (CPU and coprocessor) plus frame-buffer observer.
    modport master (
        output cpu_req, cpu_addr, cpu_data,
        output str_start, str_slot, str_valid, str_data,
        input  cpu_gnt, str_ready, str_busy, str_done,
        input  fb_we, fb_waddr, fb_wdata
    );

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_addr, cpu_data,
        input  str_start, str_slot, str_valid, str_data,
        output cpu_gnt, str_ready, str_busy, str_done,
        output fb_we, fb_waddr, fb_wdata
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: merges CPU single-pixel writes with a 256x256
// coprocessor image stream into one registered write port. The stream has
// priority; a starvation counter forces a CPU grant after STARVE_MAX denials.
module fb_write_arbiter #(
    parameter int unsigned DW         = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    fb_write_if.slave  bus
);
    localparam int unsigned AW = 17;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] SLOT1_BASE = AW'(256);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          str_ready_c;
    logic          cpu_gnt_c;
    logic          str_acc;
    logic [AW-1:0] str_addr;

    // Row stride is 512 so two 256-wide images sit side by side.
    assign str_addr = base_q + {row_q, 9'b0} + AW'(col_q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            starve_q <= '0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            row_q    <= row_d;
            col_q    <= col_d;
            starve_q <= starve_d;
            done_q   <= done_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state, arbitration and write-port selection.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        row_d       = row_q;
        col_d       = col_q;
        starve_d    = '0;
        done_d      = 1'b0;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        str_ready_c = 1'b0;
        cpu_gnt_c   = 1'b0;
        str_acc     = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_gnt_c = bus.cpu_req;
                if (bus.str_start) begin
                    state_d = STREAM;
                    base_d  = bus.str_slot ? SLOT1_BASE : '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end

            STREAM: begin
                if (bus.str_start) begin
                    // Restart: no pixel is taken on the abort cycle so the
                    // next stream write is the new image's first address.
                    base_d = bus.str_slot ? SLOT1_BASE : '0;
                    row_d  = '0;
                    col_d  = '0;
                end else begin
                    str_ready_c = !((starve_q == STARVE_LIM) && bus.cpu_req);
                end

                str_acc   = bus.str_valid & str_ready_c;
                cpu_gnt_c = bus.cpu_req & ~str_acc;

                if (bus.cpu_req && !cpu_gnt_c) begin
                    starve_d = (starve_q == STARVE_LIM) ? starve_q
                                                        : SW'(starve_q + SW'(1));
                end

                if (str_acc) begin
                    col_d = CW'(col_q + CW'(1));
                    if (col_q == '1) begin
                        row_d = CW'(row_q + CW'(1));
                    end
                    if ((row_q == '1) && (col_q == '1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (str_acc) begin
            we_d    = 1'b1;
            waddr_d = str_addr;
            wdata_d = bus.str_data;
        end else if (cpu_gnt_c) begin
            we_d    = 1'b1;
            waddr_d = bus.cpu_addr;
            wdata_d = bus.cpu_data;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_c;
    assign bus.str_ready = str_ready_c;
    assign bus.str_busy  = (state_q == STREAM);
    assign bus.str_done  = done_q;
    assign bus.fb_we     = we_q;
    assign bus.fb_waddr  = waddr_q;
    assign bus.fb_wdata  = wdata_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: CPU idle writes, stream priority and
// starvation grant, stall behaviour, mid-transfer reset, abort/restart and a
// full slot-1 image transfer.
module tb_fb_write_arbiter;
    logic clk;
    logic rst_n;

    int n_assert;
    int n_fail;
    int pix;
    int base;
    bit prev_str;

    fb_write_if #(.DW(8)) bus ();

    fb_write_arbiter #(.DW(8), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Image pixel k lands at base + row*512 + col.
    function automatic logic [31:0] exp_addr(input int b, input int k);
        return 32'(b + (k / 256) * 512 + (k % 256));
    endfunction

    // Write port must show the stream pixel accepted on the previous cycle.
    task automatic check_prev_str();
        check("str_we", 32'(bus.fb_we), 32'd1);
        check("str_addr", 32'(bus.fb_waddr), exp_addr(base, pix - 1));
        check("str_data", 32'(bus.fb_wdata), 32'((pix - 1) & 255));
    endtask

    task automatic stream_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (prev_str) check_prev_str();
            bus.str_start = 1'b0;
            bus.str_valid = 1'b1;
            bus.str_data  = 8'(pix);
            #1;
            check("str_ready", 32'(bus.str_ready), 32'd1);
            check("str_done_low", 32'(bus.str_done), 32'd0);
            pix++;
            prev_str = 1'b1;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        pix      = 0;
        base     = 0;
        prev_str = 1'b0;
        rst_n         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_data  = '0;
        bus.str_start = 1'b0;
        bus.str_slot  = 1'b0;
        bus.str_valid = 1'b0;
        bus.str_data  = '0;

        // Reset values
        #3;
        check("rst_we", 32'(bus.fb_we), 32'd0);
        check("rst_waddr", 32'(bus.fb_waddr), 32'd0);
        check("rst_wdata", 32'(bus.fb_wdata), 32'd0);
        check("rst_done", 32'(bus.str_done), 32'd0);
        check("rst_busy", 32'(bus.str_busy), 32'd0);
        check("rst_ready", 32'(bus.str_ready), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_write", 32'(bus.fb_we), 32'd0);
        end

        // CPU write in IDLE
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 17'd5;
        bus.cpu_data = 8'hAA;
        #1;
        check("idle_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        check("idle_ready", 32'(bus.str_ready), 32'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        check("idle_cpu_we", 32'(bus.fb_we), 32'd1);
        check("idle_cpu_addr", 32'(bus.fb_waddr), 32'd5);
        check("idle_cpu_data", 32'(bus.fb_wdata), 32'hAA);
        @(negedge clk);
        check("hold_we", 32'(bus.fb_we), 32'd0);
        check("hold_addr", 32'(bus.fb_waddr), 32'd5);
        check("hold_data", 32'(bus.fb_wdata), 32'hAA);

        // Start slot 0 with valid already high: no accept on the start cycle
        bus.str_start = 1'b1;
        bus.str_slot  = 1'b0;
        bus.str_valid = 1'b1;
        bus.str_data  = 8'h77;
        #1;
        check("start_ready", 32'(bus.str_ready), 32'd0);
        check("start_busy", 32'(bus.str_busy), 32'd0);
        base = 0;
        pix = 0;
        prev_str = 1'b0;
        stream_pixels(10);
        check("stream_busy", 32'(bus.str_busy), 32'd1);

        // CPU contention: four denials, grant on the fifth request cycle
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            check_prev_str();
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 17'h1F000;
            bus.cpu_data = 8'h55;
            bus.str_data = 8'(pix);
            #1;
            check("deny_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
            check("deny_ready", 32'(bus.str_ready), 32'd1);
            pix++;
        end
        @(negedge clk);
        check_prev_str();
        bus.str_data = 8'(pix);
        #1;
        check("starve_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        check("starve_ready", 32'(bus.str_ready), 32'd0);
        @(negedge clk);
        check("starve_we", 32'(bus.fb_we), 32'd1);
        check("starve_addr", 32'(bus.fb_waddr), 32'h1F000);
        check("starve_data", 32'(bus.fb_wdata), 32'h55);
        bus.cpu_req  = 1'b0;
        bus.str_data = 8'(pix);
        #1;
        check("resume_ready", 32'(bus.str_ready), 32'd1);
        check("resume_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        pix++;
        prev_str = 1'b1;
        stream_pixels(5);

        // Stream stall: CPU is granted immediately, counters hold
        @(negedge clk);
        check_prev_str();
        bus.str_valid = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 17'h00123;
        bus.cpu_data  = 8'h3C;
        #1;
        check("stall_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        check("stall_ready", 32'(bus.str_ready), 32'd1);
        prev_str = 1'b0;
        @(negedge clk);
        check("stall_cpu_we", 32'(bus.fb_we), 32'd1);
        check("stall_cpu_addr", 32'(bus.fb_waddr), 32'h00123);
        check("stall_cpu_data", 32'(bus.fb_wdata), 32'h3C);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("stall_no_write", 32'(bus.fb_we), 32'd0);
        stream_pixels(300 - pix);

        // Reset mid-transfer after 300 pixels
        @(negedge clk);
        check_prev_str();
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(bus.fb_we), 32'd0);
        check("mid_rst_busy", 32'(bus.str_busy), 32'd0);
        check("mid_rst_addr", 32'(bus.fb_waddr), 32'd0);
        check("mid_rst_done", 32'(bus.str_done), 32'd0);
        check("mid_rst_ready", 32'(bus.str_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.str_valid = 1'b0;
        @(negedge clk);
        check("post_rst_no_write", 32'(bus.fb_we), 32'd0);
        bus.str_start = 1'b1;
        bus.str_slot  = 1'b0;
        bus.str_valid = 1'b1;
        #1;
        check("restart_ready", 32'(bus.str_ready), 32'd0);
        base = 0;
        pix = 0;
        prev_str = 1'b0;
        stream_pixels(1000);

        // Abort after 1000 pixels and restart in slot 1
        @(negedge clk);
        check_prev_str();
        bus.str_start = 1'b1;
        bus.str_slot  = 1'b1;
        #1;
        check("abort_ready", 32'(bus.str_ready), 32'd0);
        check("abort_busy", 32'(bus.str_busy), 32'd1);
        base = 256;
        pix = 0;
        @(negedge clk);
        check("abort_no_write", 32'(bus.fb_we), 32'd0);
        check("abort_no_done", 32'(bus.str_done), 32'd0);
        bus.str_start = 1'b0;
        bus.str_data  = 8'd0;
        #1;
        check("slot1_ready", 32'(bus.str_ready), 32'd1);
        pix = 1;
        prev_str = 1'b1;
        stream_pixels(65535);

        // Final pixel written, done pulse, back in IDLE
        @(negedge clk);
        check("last_we", 32'(bus.fb_we), 32'd1);
        check("last_addr", 32'(bus.fb_waddr), 32'd131071);
        check("last_data", 32'(bus.fb_wdata), 32'hFF);
        check("done_pulse", 32'(bus.str_done), 32'd1);
        check("done_busy", 32'(bus.str_busy), 32'd0);
        #1;
        check("done_idle_ready", 32'(bus.str_ready), 32'd0);
        @(negedge clk);
        check("done_cleared", 32'(bus.str_done), 32'd0);
        check("done_no_write", 32'(bus.fb_we), 32'd0);
        bus.str_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
